// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 asynchronous serial receiver, LSB first.
// Samples UART_RXD at mid-bit using a CLKS_PER_BIT bit timer. Each received
// byte appears on rx_data with a one-cycle rx_valid strobe. A low stop bit
// gives a one-cycle rx_frame_err strobe, and the receiver then waits for the
// line to return high before it looks for the next frame.
module uart_rx_8n1 #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW           = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  logic rxs;
  assign rxs = sync2_q;

  // State register, synchronizer, datapath and strobe flops.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge, whatever order the lines are in.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state, bit timing, sampling and strobe generation.
  always_comb begin
    // NOTE: every signal gets a default first. Paths that do not assign a
    // signal then hold its value, and no latch is inferred.
    state_d = state_q;
    sync1_d = UART_RXD;
    sync2_d = sync1_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rxs) state_d = S_START;
      end

      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          // A start bit that is already high again at mid-bit is a glitch.
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxs) begin
            // Leaving at mid stop bit lets a start bit follow immediately.
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_BREAK: begin
        // Stay here while the line is low, so a long break gives one error strobe.
        timer_d = '0;
        if (rxs) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial receiver for the board UART line (UART_RXD): accepts asynchronous 8N1 frames, LSB first, and presents each received byte as a parallel word with a one-cycle valid strobe. It is the receiving end of the same serial link the top level drives on UART_TXD. It sits between the UART_RXD pin and the design's command/data logic and runs in the CLOCK_50 domain.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, CLK_HZ/BAUD (derived, localparam), clocks per bit; must be >= 8
- CLOCK_50  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- UART_RXD  input  1  serial line, idle high, asynchronous to CLOCK_50
- rx_data  output  8  last correctly framed byte; held until next good frame
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_busy  output  1  high from start-edge detect until return to IDLE

## Operation
- Input conditioning: UART_RXD passes through a 2-flop synchronizer (both flops reset to 1); FSM uses the second flop output (rxs) only.
- Bit timer: counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit index 0..7, 3 bits; shift register 8 bits, right-shift, new bit into MSB.
- States:
  - IDLE: rx_busy=0. rxs==0 -> START, timer cleared.
  - START: on timer == CLKS_PER_BIT/2-1 (mid start bit): rxs==0 -> DATA, timer cleared, index 0; rxs==1 -> IDLE (glitch rejected, no strobe).
  - DATA: on timer == CLKS_PER_BIT-1: sample rxs into shift register, timer cleared; index 7 -> STOP, else index+1.
  - STOP: on timer == CLKS_PER_BIT-1 (mid stop bit): rxs==1 -> rx_data <= shift, rx_valid=1, -> IDLE; rxs==0 -> rx_frame_err=1, rx_data unchanged, -> BREAK.
  - BREAK: wait until rxs==1, then -> IDLE. Line held low (break) produces exactly one rx_frame_err, no further strobes.
- rx_valid and rx_frame_err are registered, never both high, each high for exactly one cycle per frame.
- Returning to IDLE at mid stop bit allows back-to-back frames with no idle gap.
- No parity, no FIFO; a consumer that misses rx_valid loses nothing until the next frame overwrites rx_data.

## Timing
- Reset values: rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, FSM=IDLE, sync flops=1.
- reset asserted mid-frame: immediately to reset values, partial byte discarded, no strobe; after release, a frame already in progress on the line may yield a frame error or garbage byte — acceptable.
- Start detect: 2 cycles after UART_RXD falling edge (synchronizer), START entered the following cycle.
- Sample points: start at CLKS_PER_BIT/2 clocks after detect; data bit n at CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT; stop at CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (±1 cycle).
- rx_valid latency: ≈ 9.5 bit times + 3 cycles after the start-bit falling edge on the pin.
- Tolerates ±3% baud mismatch at CLKS_PER_BIT >= 16.

## Test plan
Bench parameters: CLK_HZ=1_600_000, BAUD=100_000 (CLKS_PER_BIT=16); transmitter model drives UART_RXD at 16 clocks/bit.
- Reset: assert reset 3 cycles with UART_RXD=1 -> all outputs 0, rx_busy stays 0 for 100 idle cycles.
- Single byte 0xA5 -> exactly one rx_valid pulse ~155 cycles after start edge, rx_data=8'hA5, rx_frame_err never high.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three rx_valid pulses, rx_data 8'h00, 8'hFF, 8'h3C in order, spacing 160 cycles.
- Framing error: send 0x55 with stop bit driven 0, then hold line low 40 cycles, then high -> one rx_frame_err pulse, no rx_valid, rx_data keeps previous value; next good 0x81 -> rx_valid, rx_data=8'h81.
- Glitch: UART_RXD low for 4 cycles then high -> rx_busy pulses, returns to IDLE, no rx_valid / rx_frame_err.
- Reset mid-frame: assert reset during bit 4 of 0xC3 -> outputs reset immediately, no strobe; after release and idle line, 0x7E received correctly.
